// File: rtl/cop0_status_ctrl.sv
// CP0 Status register owner. Previews the Status result of the op in EX,
// holds it pending for one cycle, then commits it unless flushed. A small
// save stack of {ERL,EXL,IE} backs nested exceptions.
module cop0_status_ctrl #(
    parameter int          DATA_W      = 32,
    parameter int          STACK_DEPTH = 2,
    parameter int          IDX_IE      = 0,
    parameter int          IDX_EXL     = 1,
    parameter int          IDX_ERL     = 2,
    parameter logic [31:0] WR_MASK     = 32'h0000_FF17,
    parameter logic [31:0] RESET_VAL   = 32'h0040_0004
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ex_valid,
    input  logic [2:0]                           ex_op,
    input  logic [DATA_W-1:0]                    ex_rt,
    input  logic                                 stall,
    input  logic                                 flush,
    output logic [DATA_W-1:0]                    y,
    output logic [DATA_W-1:0]                    status_o,
    output logic                                 int_en_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     depth_o,
    output logic                                 ovf_o,
    output logic                                 unf_o
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [DATA_W-1:0] MASK = DATA_W'(WR_MASK);
    localparam logic [DATA_W-1:0] RST  = DATA_W'(RESET_VAL);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MTC0  = 3'd1,
        OP_EI    = 3'd2,
        OP_DI    = 3'd3,
        OP_EXC   = 3'd4,
        OP_ERET  = 3'd5,
        OP_RD_RT = 3'd6
    } op_e;

    // committed state
    logic [DATA_W-1:0]                status_q, status_d;
    logic [STACK_DEPTH-1:0][2:0]      stk_q, stk_d;
    logic [DEPTH_W-1:0]               depth_q, depth_d;
    logic                             ovf_q, ovf_d;
    logic                             unf_q, unf_d;

    // pending (captured, not yet committed) op
    logic                             pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0]                pend_val_q, pend_val_d;
    op_e                              pend_op_q, pend_op_d;
    logic [2:0]                       pend_sav_q, pend_sav_d;

    // stack/flag view as it will be once the pending op commits
    logic [STACK_DEPTH-1:0][2:0]      stk_c;
    logic [DEPTH_W-1:0]               depth_c;
    logic                             ovf_c, unf_c;

    logic [DATA_W-1:0]                base, prev;
    op_e                              op_eff;
    logic                             capture, commit;

    // Apply the pending op to the stack; this is both the commit target and
    // the stack view that a back-to-back ERET in EX must see.
    always_comb begin
        stk_c   = stk_q;
        depth_c = depth_q;
        ovf_c   = ovf_q;
        unf_c   = unf_q;
        if (pend_vld_q) begin
            if (pend_op_q == OP_EXC) begin
                // entry 0 is the top; the oldest entry falls off the end when full
                for (int i = STACK_DEPTH - 1; i > 0; i--) stk_c[i] = stk_q[i-1];
                stk_c[0] = pend_sav_q;
                if (depth_q == DEPTH_W'(STACK_DEPTH)) ovf_c = 1'b1;
                else                                 depth_c = depth_q + 1'b1;
            end else if (pend_op_q == OP_ERET) begin
                if (depth_q != '0) begin
                    for (int i = 0; i < STACK_DEPTH - 1; i++) stk_c[i] = stk_q[i+1];
                    depth_c = depth_q - 1'b1;
                end else begin
                    unf_c = 1'b1;
                end
            end
        end
    end

    // Preview of the EX op on the forwarded base, plus capture/commit decisions.
    always_comb begin
        base    = pend_vld_q ? pend_val_q : status_q;
        op_eff  = (ex_valid && ex_op <= 3'd6) ? op_e'(ex_op) : OP_NONE;
        prev    = base;
        case (op_eff)
            OP_MTC0: prev = (base & ~MASK) | (ex_rt & MASK);
            OP_EI:   prev[IDX_IE]  = 1'b1;
            OP_DI:   prev[IDX_IE]  = 1'b0;
            OP_EXC:  prev[IDX_EXL] = 1'b1;
            OP_ERET: begin
                if (depth_c != '0) begin
                    prev[IDX_ERL] = stk_c[0][2];
                    prev[IDX_EXL] = stk_c[0][1];
                    prev[IDX_IE]  = stk_c[0][0];
                end else if (base[IDX_ERL]) begin
                    prev[IDX_ERL] = 1'b0;
                end else begin
                    prev[IDX_EXL] = 1'b0;
                end
            end
            default: prev = base;
        endcase
        y       = (op_eff == OP_RD_RT) ? ex_rt : prev;
        capture = ex_valid & ~stall & ~flush;
        commit  = pend_vld_q & ~flush;
    end

    // Next-state: commit writes Status/stack/flags, capture loads pending.
    always_comb begin
        status_d   = commit ? pend_val_q : status_q;
        stk_d      = commit ? stk_c      : stk_q;
        depth_d    = commit ? depth_c    : depth_q;
        ovf_d      = commit ? ovf_c      : ovf_q;
        unf_d      = commit ? unf_c      : unf_q;
        pend_vld_d = capture;
        pend_val_d = prev;
        pend_op_d  = op_eff;
        pend_sav_d = {base[IDX_ERL], base[IDX_EXL], base[IDX_IE]};
    end

    // State registers with async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= RST;
            stk_q      <= '0;
            depth_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
            pend_op_q  <= OP_NONE;
            pend_sav_q <= '0;
        end else begin
            status_q   <= status_d;
            stk_q      <= stk_d;
            depth_q    <= depth_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
            pend_op_q  <= pend_op_d;
            pend_sav_q <= pend_sav_d;
        end
    end

    assign status_o = status_q;
    assign int_en_o = status_q[IDX_IE] & ~status_q[IDX_EXL] & ~status_q[IDX_ERL];
    assign depth_o  = depth_q;
    assign ovf_o    = ovf_q;
    assign unf_o    = unf_q;

endmodule

// File: tb/tb_cop0_status_ctrl.sv
// Bench for cop0_status_ctrl: directed scenarios plus random ops, checked
// against an op-replay model (committed state + one pending op, stack as a queue).
module tb_cop0_status_ctrl;

    localparam int          D  = 2;
    localparam logic [31:0] WM = 32'h0000_FF17;
    localparam logic [31:0] RV = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_rt;
    logic        stall, flush;
    logic [31:0] y, status_o;
    logic        int_en_o, ovf_o, unf_o;
    logic [1:0]  depth_o;

    cop0_status_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_rt(ex_rt), .stall(stall), .flush(flush), .y(y),
        .status_o(status_o), .int_en_o(int_en_o), .depth_o(depth_o),
        .ovf_o(ovf_o), .unf_o(unf_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // committed model state
    logic [31:0] c_st;
    logic [2:0]  c_q[$];
    bit          c_ovf, c_unf;
    // pending op (replayed at commit)
    bit          p_vld;
    logic [2:0]  p_op;
    logic [31:0] p_rt;
    // scratch state the op rules act on
    logic [31:0] b_st;
    logic [2:0]  b_q[$];
    bit          b_ovf, b_unf;

    task automatic model_reset();
        c_st = RV; c_q = {}; c_ovf = 0; c_unf = 0; p_vld = 0; p_op = 0; p_rt = 0;
    endtask

    // One op applied to the scratch state, straight from the op rules.
    task automatic adv_b(input logic [2:0] op, input logic [31:0] rt);
        logic [2:0] e;
        case (op)
            3'd1: b_st = (b_st & ~WM) | (rt & WM);
            3'd2: b_st[0] = 1'b1;
            3'd3: b_st[0] = 1'b0;
            3'd4: begin
                b_q.push_front(b_st[2:0]);
                if (b_q.size() > D) begin
                    e = b_q.pop_back();
                    b_ovf = 1;
                end
                b_st[1] = 1'b1;
            end
            3'd5: begin
                if (b_q.size() > 0) begin
                    e = b_q.pop_front();
                    b_st[2:0] = e;
                end else begin
                    b_unf = 1;
                    if (b_st[2]) b_st[2] = 1'b0;
                    else         b_st[1] = 1'b0;
                end
            end
            default: ;
        endcase
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance model at the edge.
    task automatic step(input bit v, input logic [2:0] op, input logic [31:0] rt,
                        input bit stl, input bit fl);
        logic [31:0] bs, exp_y;
        logic [2:0]  bq[$];
        bit          bo, bu;
        ex_valid = v; ex_op = op; ex_rt = rt; stall = stl; flush = fl;
        #1;
        b_st = c_st; b_q = c_q; b_ovf = c_ovf; b_unf = c_unf;
        if (p_vld) adv_b(p_op, p_rt);
        bs = b_st; bq = b_q; bo = b_ovf; bu = b_unf;
        if (v) adv_b(op, rt);
        exp_y = (v && op == 3'd6) ? rt : b_st;
        chk("y", y, exp_y);
        chk("status", status_o, c_st);
        chk("depth", 32'(depth_o), 32'(c_q.size()));
        chk("ovf", 32'(ovf_o), 32'(c_ovf));
        chk("unf", 32'(unf_o), 32'(c_unf));
        chk("int_en", 32'(int_en_o), 32'(c_st[0] & ~c_st[1] & ~c_st[2]));
        @(posedge clk);
        if (p_vld && !fl) begin
            c_st = bs; c_q = bq; c_ovf = bo; c_unf = bu;
        end
        p_vld = v && !stl && !fl;
        p_op = op; p_rt = rt;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 3'd0, 32'h0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 0; ex_op = 0; ex_rt = 0; stall = 0; flush = 0;
        model_reset();
        #12;
        chk("rst_status", status_o, RV);
        chk("rst_depth", 32'(depth_o), 32'd0);
        chk("rst_y", y, RV);
        @(negedge clk);
        rst_n = 1'b1;

        // MTC0 all-ones then EI back-to-back
        step(1, 3'd1, 32'hFFFF_FFFF, 0, 0);
        step(1, 3'd2, 32'h0, 0, 0);
        idle(2);
        chk("mtc0_ei_status", status_o, 32'h0040_FF17);

        // nested exceptions overflow, then returns underflow
        step(1, 3'd1, 32'h0000_0001, 0, 0);
        step(1, 3'd4, 32'h0, 0, 0);
        step(1, 3'd4, 32'h0, 0, 0);
        step(1, 3'd4, 32'h0, 0, 0);
        idle(2);
        chk("exc_depth", 32'(depth_o), 32'd2);
        chk("exc_ovf", 32'(ovf_o), 32'd1);
        step(1, 3'd5, 32'h0, 0, 0);
        step(1, 3'd5, 32'h0, 0, 0);
        idle(2);
        chk("eret_depth", 32'(depth_o), 32'd0);
        chk("eret_unf0", 32'(unf_o), 32'd0);
        step(1, 3'd5, 32'h0, 0, 0);
        idle(2);
        chk("eret_unf1", 32'(unf_o), 32'd1);

        // empty-stack ERET: ERL first, then EXL
        step(1, 3'd1, 32'h0000_0006, 0, 0);
        step(1, 3'd5, 32'h0, 0, 0);
        idle(2);
        chk("eret_erl", status_o & 32'h7, 32'h2);
        step(1, 3'd5, 32'h0, 0, 0);
        idle(2);
        chk("eret_exl", status_o & 32'h7, 32'h0);

        // EI killed by a flush the next cycle
        step(1, 3'd2, 32'h0, 0, 0);
        step(0, 3'd0, 32'h0, 0, 1);
        idle(2);
        chk("flush_ie", status_o & 32'h1, 32'h0);

        // op held by stall for 3 cycles then released
        step(1, 3'd2, 32'h0, 1, 0);
        step(1, 3'd2, 32'h0, 1, 0);
        step(1, 3'd2, 32'h0, 1, 0);
        step(1, 3'd2, 32'h0, 0, 0);
        idle(2);
        chk("stall_ie", status_o & 32'h1, 32'h1);

        // RD_RT passthrough
        ex_valid = 1; ex_op = 3'd6; ex_rt = 32'h1234_5678; #1;
        chk("rdrt_y", y, 32'h1234_5678);
        step(1, 3'd6, 32'h1234_5678, 0, 0);
        idle(2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rt;
            rt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h7);
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 6)), rt,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
        end

        // async reset in the middle of a cycle with an op pending
        ex_valid = 1; ex_op = 3'd1; ex_rt = 32'hFFFF_FFFF; stall = 0; flush = 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_status", status_o, RV);
        chk("midrst_depth", 32'(depth_o), 32'd0);
        chk("midrst_ovf", 32'(ovf_o), 32'd0);
        ex_valid = 0; ex_op = 3'd0; #1;
        chk("midrst_y", y, RV);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 6)), $urandom,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
